bht_predictor: RTL

Parametrised branch history table predictor: an array of 2^INDEX_W saturating counters indexed by PC, in bimodal or gshare mode. Sits in the fetch stage and supplies taken/not-taken predictions. It is trained from the execute stage with resolved branch outcomes. It also keeps a saturating mispredict counter for performance monitoring.

---
 rtl/bht_predictor_pkg.sv | 23 ++
 rtl/bht_predictor_if.sv | 34 +++
 rtl/bp_sat_cnt.sv | 19 +
 rtl/bht_predictor.sv | 108 ++++++++++
 4 files changed

// File: rtl/bht_predictor_pkg.sv
// Shared constants and helpers for the branch history table predictor.
// Holds mode selectors, 2-bit counter state names and counter reset value.
package bp_pkg;

  localparam int unsigned MODE_BIMODAL = 0;
  localparam int unsigned MODE_GSHARE  = 1;

  localparam int unsigned PC_W = 32;

  // Named states of the classic 2-bit counter.
  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } cnt2_e;

  // Weakly-not-taken value for a counter of the given width.
  function automatic int unsigned cnt_init(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bht_predictor_if.sv
// Fetch-side predict and execute-side update signals of the predictor.
// master = pipeline side, slave = predictor.
interface bht_predictor_if #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned GHR_W  = 6,
  parameter int unsigned STAT_W = 16
) ();
  import bp_pkg::*;

  logic              pred_req;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_vld;
  logic              pred_taken;
  logic [CNT_W-1:0]  pred_cnt;

  logic              upd_vld;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic              upd_pred;

  logic [GHR_W-1:0]  ghr;
  logic [STAT_W-1:0] mispred_cnt;

  modport master (
    output pred_req, pred_pc, upd_vld, upd_pc, upd_taken, upd_pred,
    input  pred_vld, pred_taken, pred_cnt, ghr, mispred_cnt
  );

  modport slave (
    input  pred_req, pred_pc, upd_vld, upd_pc, upd_taken, upd_pred,
    output pred_vld, pred_taken, pred_cnt, ghr, mispred_cnt
  );

endinterface

// File: rtl/bp_sat_cnt.sv
// Combinational next value of a CNT_W-bit saturating up/down counter.
module bp_sat_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             taken,
  output logic [CNT_W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != {CNT_W{1'b1}}) nxt = cur + CNT_W'(1);
    end else if (cur != '0) begin
      nxt = cur - CNT_W'(1);
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Bimodal / gshare branch history table with write-first bypass,
// global history register and saturating mispredict statistics.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned GHR_W   = 6,
  parameter int unsigned MODE    = MODE_BIMODAL,
  parameter int unsigned STAT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  bht_predictor_if.slave bus
);

  localparam int unsigned    TAB_N   = 32'd1 << INDEX_W;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_init(CNT_W));

  if (CNT_W < 2 || GHR_W < 1 || GHR_W > INDEX_W || INDEX_W > 29 || MODE > 1)
  begin : g_bad_param
    $error("bht_predictor: illegal parameter combination");
  end

  logic [CNT_W-1:0]   r_tab [TAB_N];
  logic [GHR_W-1:0]   r_ghr;
  logic [STAT_W-1:0]  r_mis;
  logic               r_pred_vld;
  logic               r_pred_taken;
  logic [CNT_W-1:0]   r_pred_cnt;

  logic [INDEX_W-1:0] w_hash;
  logic [INDEX_W-1:0] w_pred_idx;
  logic [INDEX_W-1:0] w_upd_idx;
  logic [CNT_W-1:0]   w_upd_cur;
  logic [CNT_W-1:0]   w_upd_nxt;
  logic [CNT_W-1:0]   w_pred_cur;
  logic [GHR_W-1:0]   w_ghr_nxt;
  logic               w_bypass;
  logic               w_mispred;
  logic               w_unused_pc;

  // History is folded into the index only in gshare mode; both paths see the pre-update ghr.
  assign w_hash     = (MODE == MODE_GSHARE) ? INDEX_W'(r_ghr) : '0;
  assign w_pred_idx = bus.pred_pc[INDEX_W+1:2] ^ w_hash;
  assign w_upd_idx  = bus.upd_pc[INDEX_W+1:2] ^ w_hash;

  assign w_unused_pc = ^{bus.pred_pc[PC_W-1:INDEX_W+2], bus.pred_pc[1:0],
                         bus.upd_pc[PC_W-1:INDEX_W+2], bus.upd_pc[1:0]};

  assign w_upd_cur = r_tab[w_upd_idx];

  bp_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_sat_cnt (
    .cur   (w_upd_cur),
    .taken (bus.upd_taken),
    .nxt   (w_upd_nxt)
  );

  // Write-first: a same-cycle update to the predicted entry is forwarded.
  assign w_bypass   = bus.pred_req && bus.upd_vld && (w_pred_idx == w_upd_idx);
  assign w_pred_cur = w_bypass ? w_upd_nxt : r_tab[w_pred_idx];

  // Truncating {ghr, taken} to GHR_W drops the oldest outcome; also valid for GHR_W = 1.
  assign w_ghr_nxt = GHR_W'({r_ghr, bus.upd_taken});
  assign w_mispred = bus.upd_vld && (bus.upd_pred != bus.upd_taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(TAB_N); i++) r_tab[i] <= CNT_RST;
    end else if (bus.upd_vld) begin
      r_tab[w_upd_idx] <= w_upd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
      r_mis <= '0;
    end else begin
      if (bus.upd_vld) r_ghr <= w_ghr_nxt;
      if (w_mispred && (r_mis != {STAT_W{1'b1}})) r_mis <= r_mis + STAT_W'(1);
    end
  end

  // Prediction outputs hold their last value when no request is made.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pred_vld   <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_cnt   <= '0;
    end else begin
      r_pred_vld <= bus.pred_req;
      if (bus.pred_req) begin
        r_pred_cnt   <= w_pred_cur;
        r_pred_taken <= w_pred_cur[CNT_W-1];
      end
    end
  end

  assign bus.pred_vld    = r_pred_vld;
  assign bus.pred_taken  = r_pred_taken;
  assign bus.pred_cnt    = r_pred_cnt;
  assign bus.ghr         = r_ghr;
  assign bus.mispred_cnt = r_mis;

endmodule
